sram_bus_arbiter: RTL
=====================

// Module: sram_bus_arbiter
// PURPOSE
//  Shares the single external 8-bit SRAM between CPU memory cycles (RAM/EMS/BIOS shadow) and CGA/Tandy video fetch.
//  Sits between the PERIPHERALS memory decode and the SRAM pins.
//  Sequences every SRAM access and inserts write recovery.
//  Holds the CPU off through cpu_ready, which feeds the io_channel_ready input of READY.
// PARAMETERS
//  ADDR_W         21  SRAM address width
//  ACCESS_CYCLES  2   clock cycles per SRAM access (>=1)
//  STARVE_MAX     4   max consecutive video grants while cpu_req pending (>=1)
// PORTS
//  clock       in   1       system clock
//  reset       in   1       asynchronous, active-high
//  cpu_req     in   1       CPU access request, level, held until cpu_ack
//  cpu_we      in   1       1=write, 0=read; stable while cpu_req
//  cpu_addr    in   ADDR_W  CPU SRAM address
//  cpu_wdata   in   8       CPU write data
//  cpu_rdata   out  8       CPU read data, valid while cpu_ack
//  cpu_ack     out  1       one-cycle completion pulse
//  cpu_ready   out  1       ~cpu_req | cpu_ack (combinational), to READY
//  vid_req     in   1       video fetch request (read only), held until vid_ack
//  vid_addr    in   ADDR_W  video fetch address
//  vid_rdata   out  8       video read data, valid while vid_ack
//  vid_ack     out  1       one-cycle completion pulse
//  sram_addr   out  ADDR_W  SRAM address
//  sram_dq_o   out  8       SRAM write data
//  sram_dq_oe  out  1       drive SRAM_DATA
//  sram_dq_i   in   8       SRAM read data
//  sram_we_n   out  1       SRAM write strobe, active low
// BEHAVIOUR
//  Reset: state=IDLE; all registered outputs 0 except sram_we_n=1. starve_cnt=0; cyc_cnt=0.
//  States:
//   IDLE: arbitrate on each clock edge, then enter VID_RD, CPU_RD or CPU_WR.
//   VID_RD / CPU_RD / CPU_WR: last exactly ACCESS_CYCLES cycles.
//   WR_REC: one cycle; sram_we_n=1, dq_oe=0; then IDLE.
//  Arbitration priority (IDLE only):
//   1) vid_req, if starve_cnt<STARVE_MAX or !cpu_req.
//   2) otherwise cpu_req.
//  A request whose ack is high this cycle is ignored for arbitration.
//  starve_cnt:
//   +1 per video grant while cpu_req is high (saturating at STARVE_MAX).
//   Cleared on a CPU grant or when cpu_req is low.
//  sram_addr: registered at the grant edge and held for the whole access state.
//  CPU_WR: sram_dq_oe=1 for the full state; sram_we_n=0 for all cycles except the first.
//   ACCESS_CYCLES=1 → we_n=0 for that single cycle.
//  Read capture: sram_dq_i is captured on the final edge of a read state into cpu_rdata or vid_rdata.
//  Ack: the matching ack is high for the one cycle after the final edge.
//  Next state after an access: writes go to WR_REC; reads go to IDLE.
//  Latency: req high before IDLE edge E → ack high in the cycle after edge E+ACCESS_CYCLES (3 cycles by default).
//  Write back-to-back throughput: ACCESS_CYCLES+2 cycles.
//  cpu_rdata / vid_rdata: hold their last value between acks.
//  Requester protocol: requests are never aborted. Deassertion of a req mid-access is ignored; the access completes and acks.
//  Reset mid-access: abort immediately. we_n=1 and dq_oe=0 asynchronously; no ack is issued.
// CONFIGURATION
//  SRAM_ARB_PERF_EN defined:
//   Adds output perf_cpu_wait[15:0], a saturating count of cycles with cpu_req=1 and cpu_ack=0.
//   Adds input perf_clr; a synchronous 1 on perf_clr clears the count.
//   Both are 0 at reset.
//  SRAM_ARB_PERF_EN undefined: these ports and the counter are absent; all other behaviour is identical.
// TESTING
//  Reset → sram_we_n=1, sram_dq_oe=0, cpu_ack=0, vid_ack=0, cpu_ready=1.
//  CPU read 0x0_1234 (sram returns 0xA5), idle arbiter → cpu_ack 3 cycles after req; cpu_rdata=0xA5; cpu_ready=0 until ack.
//  cpu_req and vid_req rise together → video served first (vid_ack).
//   CPU is then granted from IDLE; cpu_ack arrives 4 cycles after vid_ack.
//  vid_req held high continuously plus a CPU read → exactly 4 vid_acks, then the CPU access; starve_cnt returns to 0.
//  CPU write 0x5A to 0x1F000, then read → we_n low for 1 cycle, one WR_REC cycle with dq_oe=0, then read returns 0x5A.
//  Assert reset during CPU_WR cycle 2 → we_n=1 immediately, no cpu_ack; after release the arbiter sits in IDLE.

Source files
------------

// File: rtl/sram_bus_arbiter_if.sv
// rtl/sram_bus_arbiter_if.sv - CPU/video request ports and SRAM pins of the SRAM bus arbiter
interface sram_bus_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_ready;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [7:0]        vid_rdata;
  logic              vid_ack;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_dq_o;
  logic              sram_dq_oe;
  logic [7:0]        sram_dq_i;
  logic              sram_we_n;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
    output cpu_rdata, cpu_ack, cpu_ready, vid_rdata, vid_ack,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );

  // Requesters plus SRAM device side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, sram_dq_i,
    input  cpu_rdata, cpu_ack, cpu_ready, vid_rdata, vid_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - shares one 8-bit SRAM between CPU cycles and video fetch, with write recovery
// Optional SRAM_ARB_PERF_EN adds a saturating CPU wait-cycle counter (perf_clr / perf_cpu_wait).
module sram_bus_arbiter #(
  parameter int ADDR_W        = 21,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_MAX    = 4
) (
  input  logic              clock,
  input  logic              reset,
  sram_bus_arbiter_if.slave bus
`ifdef SRAM_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [15:0]       perf_cpu_wait
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VID_RD = 3'd1;
  localparam logic [2:0] CPU_RD = 3'd2;
  localparam logic [2:0] CPU_WR = 3'd3;
  localparam logic [2:0] WR_REC = 3'd4;

  localparam int            CW         = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic          WE_N_FIRST = (ACCESS_CYCLES == 1) ? 1'b0 : 1'b1;

  logic [2:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [SW-1:0] starve_cnt;
  logic          access_last;
  logic          grant_ok;
  logic          vid_win;
  logic          vid_grant;
  logic          cpu_grant;

  assign access_last = (cyc_cnt == CYC_LAST);

  // The cycle that carries an ack is a bus turnaround: the acked requester
  // still shows its old req, and nobody else is granted either.
  assign grant_ok  = (state == IDLE) && !bus.cpu_ack && !bus.vid_ack;
  assign vid_win   = bus.vid_req && ((starve_cnt < STARVE_LIM) || !bus.cpu_req);
  assign vid_grant = grant_ok && vid_win;
  assign cpu_grant = grant_ok && !vid_win && bus.cpu_req;

  assign bus.cpu_ready = !bus.cpu_req || bus.cpu_ack;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cyc_cnt        <= '0;
      bus.sram_addr  <= '0;
      bus.sram_dq_o  <= '0;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_we_n  <= 1'b1;
      bus.cpu_rdata  <= '0;
      bus.vid_rdata  <= '0;
      bus.cpu_ack    <= 1'b0;
      bus.vid_ack    <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.vid_ack <= 1'b0;
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          if (vid_grant) begin
            state         <= VID_RD;
            bus.sram_addr <= bus.vid_addr;
          end else if (cpu_grant) begin
            bus.sram_addr <= bus.cpu_addr;
            if (bus.cpu_we) begin
              state          <= CPU_WR;
              bus.sram_dq_o  <= bus.cpu_wdata;
              bus.sram_dq_oe <= 1'b1;
              bus.sram_we_n  <= WE_N_FIRST;
            end else begin
              state <= CPU_RD;
            end
          end
        end
        VID_RD, CPU_RD: begin
          if (access_last) begin
            state <= IDLE;
            if (state == VID_RD) begin
              bus.vid_rdata <= bus.sram_dq_i;
              bus.vid_ack   <= 1'b1;
            end else begin
              bus.cpu_rdata <= bus.sram_dq_i;
              bus.cpu_ack   <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        CPU_WR: begin
          if (access_last) begin
            state          <= WR_REC;
            bus.sram_we_n  <= 1'b1;
            bus.sram_dq_oe <= 1'b0;
            bus.cpu_ack    <= 1'b1;
          end else begin
            cyc_cnt       <= cyc_cnt + 1'b1;
            bus.sram_we_n <= 1'b0;
          end
        end
        WR_REC:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.cpu_req || cpu_grant) begin
      starve_cnt <= '0;
    end else if (vid_grant && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cpu_wait <= '0;
    end else if (perf_clr) begin
      perf_cpu_wait <= '0;
    end else if (bus.cpu_req && !bus.cpu_ack && (perf_cpu_wait != 16'hFFFF)) begin
      perf_cpu_wait <= perf_cpu_wait + 16'd1;
    end
  end
`else
  // No wait-cycle counter in this build.
`endif

endmodule
